// File: rtl/doodle_sprite_pkg.sv
// rtl/doodle_sprite_pkg.sv - shared sprite geometry constants and types
package doodle_sprite_pkg;
    localparam int SPR_W     = 29;
    localparam int SPR_H     = 30;
    localparam int SPR_DEPTH = SPR_W * SPR_H;
    localparam int ADDR_W    = 15;

    typedef logic [23:0]        rgb_t;
    typedef logic signed [11:0] coord_t;

    localparam rgb_t KEY_RGB = 24'hFFFFFF;
endpackage

// File: rtl/sprite_hit_addr.sv
// rtl/sprite_hit_addr.sv - combinational sprite hit test, mirroring and RAM address
module sprite_hit_addr
    import doodle_sprite_pkg::*;
(
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              de,
    input  coord_t            pos_x,
    input  coord_t            pos_y,
    input  logic              mirror,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);
    localparam coord_t             W_C = coord_t'(SPR_W);
    localparam coord_t             H_C = coord_t'(SPR_H);
    localparam logic [ADDR_W-1:0]  W_A = ADDR_W'(SPR_W);

    coord_t rel_x;
    coord_t rel_y;
    coord_t col;

    always_comb begin
        rel_x = coord_t'({2'b00, draw_x}) - pos_x;
        rel_y = coord_t'({2'b00, draw_y}) - pos_y;
        hit   = de && !rel_x[11] && (rel_x < W_C) && !rel_y[11] && (rel_y < H_C);
        col   = mirror ? (W_C - 12'sd1 - rel_x) : rel_x;
        // Only meaningful when hit; the caller holds its address otherwise.
        addr  = ADDR_W'(rel_y) * W_A + ADDR_W'(col);
    end
endmodule

// File: rtl/doodle_sprite_fetch.sv
// rtl/doodle_sprite_fetch.sv - 3-stage doodle sprite address/pixel pipeline
module doodle_sprite_fetch
    import doodle_sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic signed [10:0] SpriteX,
    input  logic signed [10:0] SpriteY,
    input  logic              facing_left,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de,
    output logic [ADDR_W-1:0] read_address,
    input  rgb_t              ram_data,
    output rgb_t              pixel_rgb,
    output logic              pixel_vis,
    output logic [9:0]        out_DrawX,
    output logic [9:0]        out_DrawY
);
    logic signed [10:0] lx_q, lx_d, ly_q, ly_d;
    logic               lf_q, lf_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               hit1_q, hit1_d, hit2_q, hit2_d, vis_q, vis_d;
    logic [9:0]         x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic [9:0]         x3_q, x3_d, y3_q, y3_d;
    rgb_t               rgb_q, rgb_d;
    logic               hit_c;
    logic [ADDR_W-1:0]  addr_c;

    sprite_hit_addr u_hit (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .de     (de),
        .pos_x  ({lx_q[10], lx_q}),
        .pos_y  ({ly_q[10], ly_q}),
        .mirror (lf_q),
        .hit    (hit_c),
        .addr   (addr_c)
    );

    always_comb begin
        lx_d = lx_q;
        ly_d = ly_q;
        lf_d = lf_q;
        // New position takes effect the cycle after the pulse, never mid-frame.
        if (frame_start) begin
            lx_d = SpriteX;
            ly_d = SpriteY;
            lf_d = facing_left;
        end
        hit1_d = hit_c;
        addr_d = hit_c ? addr_c : addr_q;
        x1_d   = DrawX;
        y1_d   = DrawY;
        hit2_d = hit1_q;
        x2_d   = x1_q;
        y2_d   = y1_q;
        vis_d  = hit2_q && (ram_data != KEY_RGB);
        rgb_d  = vis_d ? ram_data : '0;
        x3_d   = x2_q;
        y3_d   = y2_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lx_q   <= '0;
            ly_q   <= '0;
            lf_q   <= 1'b0;
            addr_q <= '0;
            hit1_q <= 1'b0;
            hit2_q <= 1'b0;
            vis_q  <= 1'b0;
            rgb_q  <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            x2_q   <= '0;
            y2_q   <= '0;
            x3_q   <= '0;
            y3_q   <= '0;
        end else begin
            lx_q   <= lx_d;
            ly_q   <= ly_d;
            lf_q   <= lf_d;
            addr_q <= addr_d;
            hit1_q <= hit1_d;
            hit2_q <= hit2_d;
            vis_q  <= vis_d;
            rgb_q  <= rgb_d;
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            x2_q   <= x2_d;
            y2_q   <= y2_d;
            x3_q   <= x3_d;
            y3_q   <= y3_d;
        end
    end

    assign read_address = addr_q;
    assign pixel_rgb    = rgb_q;
    assign pixel_vis    = vis_q;
    assign out_DrawX    = x3_q;
    assign out_DrawY    = y3_q;
endmodule

// File: tb/tb_doodle_sprite_fetch.sv
// tb/tb_doodle_sprite_fetch.sv - directed self-checking bench for doodle_sprite_fetch
module tb_doodle_sprite_fetch;
    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               frame_start = 1'b0;
    logic signed [10:0] SpriteX = '0;
    logic signed [10:0] SpriteY = '0;
    logic               facing_left = 1'b0;
    logic [9:0]         DrawX = '0;
    logic [9:0]         DrawY = '0;
    logic               de = 1'b0;
    logic [14:0]        read_address;
    logic [23:0]        ram_data;
    logic [23:0]        pixel_rgb;
    logic               pixel_vis;
    logic [9:0]         out_DrawX;
    logic [9:0]         out_DrawY;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] hold_addr = '0;

    doodle_sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .facing_left(facing_left),
        .DrawX(DrawX), .DrawY(DrawY), .de(de),
        .read_address(read_address), .ram_data(ram_data),
        .pixel_rgb(pixel_rgb), .pixel_vis(pixel_vis),
        .out_DrawX(out_DrawX), .out_DrawY(out_DrawY)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] ram_fn(input logic [14:0] a);
        if (a == 15'd0)      return 24'hFFFFFF;
        else if (a == 15'd1) return 24'h00FF00;
        else                 return {9'h15A, a};
    endfunction

    always @(posedge Clk) ram_data <= ram_fn(read_address);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic latch(input logic signed [10:0] x, input logic signed [10:0] y, input logic f);
        SpriteX = x; SpriteY = y; facing_left = f; frame_start = 1'b1; de = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pixel_check(input string name, input logic [9:0] dx, input logic [9:0] dy,
                               input logic de_i, input logic fs, input logic exp_hit,
                               input logic [14:0] exp_addr);
        logic [23:0] exp_rgb;
        logic        exp_vis;
        DrawX = dx; DrawY = dy; de = de_i; frame_start = fs;
        step();
        frame_start = 1'b0; de = 1'b0; DrawX = '0; DrawY = '0;
        if (exp_hit) hold_addr = exp_addr;
        checks++;
        if (read_address !== hold_addr) begin
            errors++;
            $display("FAIL %s addr: got %0d expected %0d", name, read_address, hold_addr);
        end
        step();
        step();
        exp_rgb = ram_fn(exp_addr);
        exp_vis = exp_hit && (exp_rgb != 24'hFFFFFF);
        checks++;
        if (pixel_vis !== exp_vis) begin
            errors++;
            $display("FAIL %s vis: got %0b expected %0b", name, pixel_vis, exp_vis);
        end
        checks++;
        if (pixel_rgb !== (exp_vis ? exp_rgb : 24'h0)) begin
            errors++;
            $display("FAIL %s rgb: got %h expected %h", name, pixel_rgb, exp_vis ? exp_rgb : 24'h0);
        end
        checks++;
        if (out_DrawX !== dx || out_DrawY !== dy) begin
            errors++;
            $display("FAIL %s coords: got %0d,%0d expected %0d,%0d", name, out_DrawX, out_DrawY, dx, dy);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; DrawX = 10'd10; DrawY = 10'd10;
        for (int i = 0; i < 4; i++) begin
            de = i[0];
            step();
            checks++;
            if (read_address !== 15'd0 || pixel_vis !== 1'b0 || pixel_rgb !== 24'h0 ||
                out_DrawX !== 10'd0 || out_DrawY !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold: addr %0d vis %0b rgb %h x %0d y %0d expected all 0",
                         read_address, pixel_vis, pixel_rgb, out_DrawX, out_DrawY);
            end
        end
        de = 1'b0;
        Reset_n = 1'b1;
        hold_addr = '0;
        DrawX = 10'd5; DrawY = 10'd5; de = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            de = 1'b0; DrawX = 10'd300; DrawY = 10'd300;
            checks++;
            if (pixel_vis !== (i == 3)) begin
                errors++;
                $display("FAIL reset_first_pixel cycle %0d: vis %0b expected %0b", i, pixel_vis, i == 3);
            end
        end
        checks++;
        if (pixel_rgb !== {9'h15A, 15'd150}) begin
            errors++;
            $display("FAIL reset_first_rgb: got %h expected %h", pixel_rgb, {9'h15A, 15'd150});
        end
        hold_addr = 15'd150;
    endtask

    task automatic test_addr_right();
        latch(11'sd100, 11'sd50, 1'b0);
        pixel_check("right_59", 10'd101, 10'd52, 1'b1, 1'b0, 1'b1, 15'd59);
        pixel_check("right_bottom_row", 10'd100, 10'd79, 1'b1, 1'b0, 1'b1, 15'd841);
        pixel_check("right_below", 10'd100, 10'd80, 1'b1, 1'b0, 1'b0, 15'd0);
        pixel_check("right_past_col", 10'd129, 10'd50, 1'b1, 1'b0, 1'b0, 15'd0);
    endtask

    task automatic test_mirror();
        latch(11'sd100, 11'sd50, 1'b1);
        pixel_check("mirror_85", 10'd101, 10'd52, 1'b1, 1'b0, 1'b1, 15'd85);
        pixel_check("mirror_841", 10'd128, 10'd79, 1'b1, 1'b0, 1'b1, 15'd841);
    endtask

    task automatic test_transparency();
        latch(11'sd100, 11'sd50, 1'b0);
        DrawY = 10'd50; DrawX = 10'd100; de = 1'b1;
        step();
        checks++;
        if (read_address !== 15'd0) begin
            errors++;
            $display("FAIL key_addr0: got %0d expected 0", read_address);
        end
        DrawX = 10'd101;
        step();
        de = 1'b0;
        checks++;
        if (read_address !== 15'd1) begin
            errors++;
            $display("FAIL key_addr1: got %0d expected 1", read_address);
        end
        step();
        checks++;
        if (pixel_vis !== 1'b0 || pixel_rgb !== 24'h0 || out_DrawX !== 10'd100) begin
            errors++;
            $display("FAIL key_transparent: vis %0b rgb %h x %0d expected 0 000000 100", pixel_vis, pixel_rgb, out_DrawX);
        end
        step();
        checks++;
        if (pixel_vis !== 1'b1 || pixel_rgb !== 24'h00FF00 || out_DrawX !== 10'd101) begin
            errors++;
            $display("FAIL key_opaque: vis %0b rgb %h x %0d expected 1 00ff00 101", pixel_vis, pixel_rgb, out_DrawX);
        end
        hold_addr = 15'd1;
    endtask

    task automatic test_clipping();
        latch(-11'sd5, 11'sd0, 1'b0);
        pixel_check("clip_left", 10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 15'd5);
        latch(11'sd630, 11'sd0, 1'b0);
        pixel_check("clip_right_639", 10'd639, 10'd0, 1'b1, 1'b0, 1'b1, 15'd9);
        pixel_check("clip_right_630", 10'd630, 10'd0, 1'b1, 1'b0, 1'b1, 15'd0);
        pixel_check("clip_right_629", 10'd629, 10'd0, 1'b1, 1'b0, 1'b0, 15'd0);
    endtask

    task automatic test_frame_latch();
        latch(11'sd100, 11'sd50, 1'b0);
        SpriteX = 11'sd300;
        pixel_check("latch_old_hit", 10'd102, 10'd51, 1'b1, 1'b0, 1'b1, 15'd31);
        pixel_check("latch_new_miss", 10'd302, 10'd51, 1'b1, 1'b0, 1'b0, 15'd0);
        latch(11'sd300, 11'sd50, 1'b0);
        pixel_check("latch_new_hit", 10'd302, 10'd51, 1'b1, 1'b0, 1'b1, 15'd31);
        pixel_check("latch_old_miss", 10'd102, 10'd51, 1'b1, 1'b0, 1'b0, 15'd0);
        pixel_check("de_low", 10'd310, 10'd60, 1'b0, 1'b0, 1'b0, 15'd0);
        SpriteX = 11'sd100;
        pixel_check("fs_same_cycle", 10'd305, 10'd52, 1'b1, 1'b1, 1'b1, 15'd63);
        pixel_check("fs_after", 10'd305, 10'd52, 1'b1, 1'b0, 1'b0, 15'd0);
    endtask

    task automatic test_reset_mid();
        DrawX = 10'd105; DrawY = 10'd52; de = 1'b1;
        step();
        step();
        de = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (read_address !== 15'd0 || pixel_vis !== 1'b0 || pixel_rgb !== 24'h0 ||
            out_DrawX !== 10'd0 || out_DrawY !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid: addr %0d vis %0b rgb %h x %0d y %0d expected all 0",
                     read_address, pixel_vis, pixel_rgb, out_DrawX, out_DrawY);
        end
        step();
        Reset_n = 1'b1;
        hold_addr = '0;
        pixel_check("after_reset_origin", 10'd5, 10'd5, 1'b1, 1'b0, 1'b1, 15'd150);
    endtask

    initial begin
        test_reset();
        test_addr_right();
        test_mirror();
        test_transparency();
        test_clipping();
        test_frame_latch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
